// File: rtl/sound_mixer.sv
// sound_mixer: multi-channel DAC sample mixer with per-channel gain/mute, saturating sum and output FIFO
module sound_mixer #(
  parameter int CHANNELS   = 2,
  parameter int IN_WIDTH   = 8,
  parameter int GAIN_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int RATE_DIV   = 80,
  parameter int DEPTH      = 4
) (
  input  logic                           clk_4e,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [CHANNELS-1:0]            ch_en,
  input  logic [CHANNELS*IN_WIDTH-1:0]   ch_value,
  input  logic [CHANNELS*GAIN_WIDTH-1:0] ch_gain,
  input  logic [CHANNELS-1:0]            ch_mute,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]         fifo_level,
  output logic                           overrun,
  output logic [7:0]                     overrun_count
);
  localparam int SW  = IN_WIDTH + GAIN_WIDTH - 1;
  localparam int AW  = SW + $clog2(CHANNELS) + 2;
  localparam int PRW = IN_WIDTH + GAIN_WIDTH + 2;
  localparam int KW  = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int CW  = RATE_DIV > 1 ? $clog2(RATE_DIV) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int HI  = (1 << (SW - 1)) - 1;
  localparam int LO  = -HI - 1;
  localparam logic [IN_WIDTH-1:0] MID = IN_WIDTH'(1 << (IN_WIDTH - 1));
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, SAT = 2'd2, PUSH = 2'd3;
  logic [IN_WIDTH-1:0]     hold_q [CHANNELS], hold_d [CHANNELS];
  logic [GAIN_WIDTH-1:0]   gain_a [CHANNELS];
  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [OUT_WIDTH-1:0]    frame_q, frame_d;
  logic [OUT_WIDTH-1:0]    mem_q [DEPTH], mem_d [DEPTH];
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]             lvl_q, lvl_d;
  logic [OUT_WIDTH-1:0]    out_q, out_d;
  logic                    overrun_q, overrun_d;
  logic [7:0]              ovc_q, ovc_d;
  logic                    tick, start, last, push, pop, accept;
  logic signed [IN_WIDTH:0]   diff;
  logic signed [GAIN_WIDTH:0] gain;
  logic signed [PRW-1:0]      prod;
  logic [SW-1:0]              sat_v;
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      hold_d[i] = ch_en[i] ? ch_value[i*IN_WIDTH +: IN_WIDTH] : hold_q[i];
      gain_a[i] = ch_gain[i*GAIN_WIDTH +: GAIN_WIDTH];
    end
    tick = enable && count_q == CW'(RATE_DIV - 1);
    start = tick && state_q == IDLE;
    last = k_q == KW'(CHANNELS - 1);
    count_d = enable && !tick ? count_q + CW'(1) : '0;
    state_d = state_q == IDLE ? (start ? ACCUM : IDLE) :
              state_q == ACCUM ? (last ? SAT : ACCUM) :
              state_q == SAT ? PUSH : IDLE;
    k_d = state_q == ACCUM ? k_q + KW'(1) : '0;
    diff = $signed({1'b0, hold_q[k_q]}) - $signed({1'b0, MID});
    gain = $signed({1'b0, gain_a[k_q]});
    prod = ch_mute[k_q] ? '0 : PRW'(diff) * PRW'(gain);
    acc_d = start ? '0 : state_q == ACCUM ? acc_q + AW'(prod) : acc_q;
    sat_v = acc_q > AW'(HI) ? SW'(HI) : acc_q < AW'(LO) ? SW'(LO) : acc_q[SW-1:0];
    frame_d = state_q == SAT ? OUT_WIDTH'(sat_v) << (OUT_WIDTH - SW) : frame_q;
    push = state_q == PUSH;
    pop = lvl_q != '0 && out_ready;
    accept = push && (lvl_q != (PW+1)'(DEPTH) || pop);
    wr_d = wr_q + PW'(accept);
    rd_d = rd_q + PW'(pop);
    lvl_d = lvl_q + (PW+1)'(accept) - (PW+1)'(pop);
    for (int j = 0; j < DEPTH; j++) mem_d[j] = accept && wr_q == PW'(j) ? frame_q : mem_q[j];
    out_d = lvl_d != '0 ? mem_d[rd_d] : out_q;
    overrun_d = push && !accept;
    ovc_d = overrun_d && ovc_q != 8'hFF ? ovc_q + 8'd1 : ovc_q;
  end
  always_ff @(posedge clk_4e) begin
    if (rst) begin
      hold_q    <= '{default: MID};
      state_q   <= IDLE;
      count_q   <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      frame_q   <= '0;
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
      lvl_q     <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
      ovc_q     <= '0;
    end else begin
      hold_q    <= hold_d;
      state_q   <= state_d;
      count_q   <= count_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      frame_q   <= frame_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lvl_q     <= lvl_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
      ovc_q     <= ovc_d;
    end
  end
  assign out_valid     = lvl_q != '0;
  assign out_data      = out_q;
  assign fifo_level    = lvl_q;
  assign overrun       = overrun_q;
  assign overrun_count = ovc_q;
endmodule

// File: tb/tb_sound_mixer.sv
// tb_sound_mixer: randomized scoreboard bench comparing sound_mixer frames against a behavioural mix model
module tb_sound_mixer;
  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, out_ready = 1'b0;
  logic [1:0] ch_en = '0, ch_mute = '0;
  logic [15:0] ch_value = 16'h8080, ch_gain = '0;
  logic out_valid, overrun;
  logic [15:0] out_data;
  logic [2:0] fifo_level;
  logic [7:0] overrun_count;
  int compared = 0, fails = 0, pops = 0, ov_pulses = 0;
  int cv [2] = '{128, 128};
  int cg [2] = '{0, 0};
  int cm [2] = '{0, 0};
  logic [15:0] exp_q [$];
  logic [15:0] last_exp = '0;
  int dir [7][6] = '{'{255, 128, 128, 128, 0, 0}, '{0, 128, 128, 128, 0, 0},
                     '{255, 255, 128, 128, 0, 0}, '{0, 0, 128, 128, 0, 0},
                     '{255, 255, 128, 128, 0, 1}, '{192, 128, 64, 128, 0, 0},
                     '{255, 128, 255, 128, 0, 0}};
  logic [15:0] dir_exp [7] = '{16'h7F00, 16'h8000, 16'h7FFE, 16'h8000, 16'h7F00, 16'h2000, 16'h7FFE};
  always #5 clk = ~clk;
  sound_mixer dut (
    .clk_4e(clk), .rst(rst), .enable(enable), .ch_en(ch_en), .ch_value(ch_value),
    .ch_gain(ch_gain), .ch_mute(ch_mute), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fifo_level(fifo_level), .overrun(overrun), .overrun_count(overrun_count)
  );
  function automatic logic [15:0] model();
    int s = 0;
    for (int k = 0; k < 2; k++) if (cm[k] == 0) s += (cv[k] - 128) * cg[k];
    s = s > 16383 ? 16383 : s < -16384 ? -16384 : s;
    return 16'(s * 2);
  endfunction
  task automatic check(string name, int act, int want);
    compared++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (overrun) ov_pulses++;
      if (!rst && out_valid && out_ready) begin
        pops++;
        compared++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          if (out_data !== e) begin
            fails++;
            $display("FAIL frame: got %h expected %h", out_data, e);
          end
        end
      end
    end
  endtask
  task automatic wait_pops(int n);
    int target = pops + n;
    int t = 0;
    while (pops < target && t < 700) begin
      @(posedge clk);
      t++;
    end
    if (pops < target) check("pop_timeout", pops, target);
  endtask
  task automatic apply(int v0, int v1, int g0, int g1, int m0, int m1);
    #1;
    cv = '{v0, v1};
    cg = '{g0, g1};
    cm = '{m0, m1};
    ch_value = {8'(v1), 8'(v0)};
    ch_gain = {8'(g1), 8'(g0)};
    ch_mute = {1'(m1), 1'(m0)};
    ch_en = 2'b11;
    @(posedge clk);
    #1 ch_en = 2'b00;
  endtask
  task automatic apply_rand();
    apply($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 255), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
  endtask
  task automatic measure_latency(string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid && n < 300);
    check(name, n, 84);
  endtask
  task automatic check_reset_outputs();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_fifo_level", int'(fifo_level), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_overrun_count", int'(overrun_count), 0);
  endtask
  initial begin
    int p0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    exp_q.push_back(16'h0000);
    rst = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    measure_latency("first_valid_latency");
    for (int p = 0; p < 7; p++) begin
      wait_pops(1);
      apply(dir[p][0], dir[p][1], dir[p][2], dir[p][3], dir[p][4], dir[p][5]);
      exp_q.push_back(dir_exp[p]);
    end
    for (int p = 0; p < 10; p++) begin
      wait_pops(1);
      apply_rand();
      exp_q.push_back(model());
    end
    wait_pops(1);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply_rand();
      if (i < 4) exp_q.push_back(model());
      repeat (79) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1 check("full_fifo_level", int'(fifo_level), 4);
    check("overrun_count", int'(overrun_count), 2);
    check("overrun_pulses", ov_pulses, 2);
    exp_q.push_back(model());
    out_ready = 1'b1;
    wait_pops(5);
    repeat (75) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs();
    cv = '{128, 128};
    exp_q.push_back(model());
    rst = 1'b0;
    measure_latency("latency_after_abort");
    wait_pops(1);
    apply_rand();
    exp_q.push_back(model());
    wait_pops(1);
    #1 out_ready = 1'b0;
    repeat (165) @(posedge clk);
    exp_q.push_back(model());
    exp_q.push_back(model());
    #1 enable = 1'b0;
    out_ready = 1'b1;
    p0 = pops;
    repeat (200) @(posedge clk);
    #1 check("drain_while_disabled", pops - p0, 2);
    check("disabled_fifo_level", int'(fifo_level), 0);
    check("disabled_out_valid", int'(out_valid), 0);
    check("empty_holds_last", int'(out_data), int'(last_exp));
    enable = 1'b1;
    exp_q.push_back(model());
    wait_pops(1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_overrun_pulses", ov_pulses, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
